pkt_injector: RTL
=================

PKT_INJECTOR -- requirements
Module: pkt_injector

Interface
REQ-001 SHALL have parameter SRC_ID, default 4'h0, 4-bit source node ID placed in every head flit.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  packet request from core.
REQ-005 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-006 SHALL have port req_dest  input  8  destination node ID.
REQ-007 SHALL have port req_len  input  4  payload word count, 0..15.
REQ-008 SHALL have port pl_data  input  32  payload word.
REQ-009 SHALL have port pl_valid  input  1  payload word valid.
REQ-010 SHALL have port pl_ready  output  1  payload word consumed when high with pl_valid.
REQ-011 SHALL have port out_data  output  32  flit toward the router input port.
REQ-012 SHALL have port out_valid  output  1  flit valid.
REQ-013 SHALL have port out_ready  input  1  router accepts the flit.
REQ-014 SHALL have ports out_head and out_tail  output  1 each  flit framing markers.

Function
REQ-015 SHALL be the transmit end of the router flit protocol: a flit transfers on a cycle with out_valid and out_ready both high.
REQ-016 SHALL hold out_data, out_head, out_tail and out_valid stable while out_valid=1 and out_ready=0.
REQ-017 SHALL register all out_* signals; the output slot is free when out_valid=0 or out_ready=1.
REQ-018 SHALL implement FSM states IDLE, HEAD, BODY, and CSUM (CSUM only per REQ-031).
REQ-019 SHALL drive req_ready=1 only in IDLE; on req_valid&&req_ready, latch dest/len and go to HEAD.
REQ-020 In HEAD, when the slot is free, SHALL load head flit {dest[31:24], len[23:20], SRC_ID[19:16], seq[15:0]}, out_head=1; head flit valid one cycle after request acceptance.
REQ-021 After the head loads: len=0 -> head also carries out_tail=1, return to IDLE; else go to BODY with remaining=len.
REQ-022 In BODY, SHALL drive pl_ready = slot free; each pl transfer loads the word as a body flit (out_head=0), decrements remaining.
REQ-023 The flit loaded when remaining=1 SHALL carry out_tail=1 and the FSM SHALL return to IDLE.
REQ-024 If pl_valid=0 in BODY and the current flit is taken, out_valid SHALL drop (bubble); packet resumes when pl_valid returns; no flit is duplicated or dropped.
REQ-025 The 16-bit seq counter SHALL increment once per head flit transferred, wrapping 16'hFFFF -> 16'h0000.
REQ-026 The next request SHALL be accepted in IDLE while the tail flit is still waiting on out_ready; its head loads only once the slot frees.
REQ-027 req_dest/req_len changes while not in IDLE SHALL have no effect.

Reset
REQ-028 On reset=1 at a clock edge SHALL force FSM=IDLE, out_valid=0, out_head=0, out_tail=0, out_data=0, seq=0, remaining=0, checksum=0.
REQ-029 During reset req_ready and pl_ready SHALL be 0; reset mid-packet SHALL abandon the packet without emitting a tail.
REQ-030 The first cycle after reset deasserts SHALL be IDLE with req_ready=1.

Configuration
REQ-031 With PKT_INJECTOR_CSUM_EN defined: SHALL accumulate XOR of all payload words of the packet; last payload flit carries out_tail=0; FSM then enters CSUM and emits one extra flit = checksum, out_tail=1, out_head=0; len=0 still yields a single head+tail flit (no checksum).
REQ-032 Without PKT_INJECTOR_CSUM_EN: no CSUM state, no checksum logic; behaviour per REQ-023.

Verification
REQ-033 Reset, then req dest=8'h05 len=0, out_ready=1 -> one flit 32'h05000000 with out_head=1, out_tail=1; req_ready=1 next cycle.
REQ-034 req dest=8'h0A len=3, SRC_ID=4'h2, payload 32'h11,32'h22,32'h33 back-to-back, out_ready=1 -> head 32'h0A320000 then three body flits, tail only on 32'h33; with CSUM_EN a fourth flit 32'h00000000 (11^22^33) with tail.
REQ-035 Same packet with out_ready low 3 cycles on second body flit -> out_data holds 32'h22 stable; pl_ready=0; no loss.
REQ-036 pl_valid gap of 2 cycles mid-packet -> out_valid=0 for those cycles, sequence intact.
REQ-037 Preload seq to 16'hFFFF via 65535 len=0 packets (or force) -> next heads carry 16'hFFFF then 16'h0000.
REQ-038 Assert reset during BODY after first payload word -> out_valid=0 next cycle, seq=0, following packet starts cleanly with head.

Source files
------------

// File: rtl/pkt_injector.sv
// ============================================================================
// Module  : pkt_injector
// Brief   : Packet injector that turns a core request plus its payload words
//           into head/body/tail flits for a router port, with a 16-bit
//           per-head sequence number.
//           Optional macro PKT_INJECTOR_CSUM_EN appends an XOR checksum flit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_injector #(
  parameter logic [3:0] SRC_ID = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_dest,
  input  logic [3:0]  req_len,
  input  logic [31:0] pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_head,
  output logic        out_tail
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_BODY = 2'd2
`ifdef PKT_INJECTOR_CSUM_EN
    ,S_CSUM = 2'd3
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  dest_q, dest_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  rem_q, rem_d;
  logic [15:0] seq_q, seq_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_head_q, out_head_d;
  logic        out_tail_q, out_tail_d;
`ifdef PKT_INJECTOR_CSUM_EN
  logic [31:0] csum_q, csum_d;
`endif

  logic        slot_free;
  logic        head_xfer;
  logic [15:0] seq_cur;

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_head  = out_head_q;
  assign out_tail  = out_tail_q;

  always_comb begin
    slot_free = !out_valid_q || out_ready;
    head_xfer = out_valid_q && out_ready && out_head_q;
    // A head may load in the same cycle the previous head leaves, so its
    // sequence field must already include that departure.
    seq_cur   = seq_q + {15'd0, head_xfer};
    req_ready = (state_q == S_IDLE) && !reset;
    pl_ready  = (state_q == S_BODY) && slot_free && !reset;

    state_d     = state_q;
    dest_d      = dest_q;
    len_d       = len_q;
    rem_d       = rem_q;
    seq_d       = seq_cur;
    out_data_d  = out_data_q;
    out_valid_d = slot_free ? 1'b0 : out_valid_q;
    out_head_d  = out_head_q;
    out_tail_d  = out_tail_q;
`ifdef PKT_INJECTOR_CSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          dest_d  = req_dest;
          len_d   = req_len;
          state_d = S_HEAD;
        end
      end
      S_HEAD: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = {dest_q, len_q, SRC_ID, seq_cur};
          out_head_d  = 1'b1;
          out_tail_d  = (len_q == 4'd0);
          rem_d       = len_q;
          state_d     = (len_q == 4'd0) ? S_IDLE : S_BODY;
`ifdef PKT_INJECTOR_CSUM_EN
          csum_d      = 32'd0;
`endif
        end
      end
      S_BODY: begin
        if (pl_valid && slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = pl_data;
          out_head_d  = 1'b0;
          rem_d       = rem_q - 4'd1;
`ifdef PKT_INJECTOR_CSUM_EN
          csum_d      = csum_q ^ pl_data;
          out_tail_d  = 1'b0;
          if (rem_q == 4'd1) state_d = S_CSUM;
`else
          out_tail_d  = (rem_q == 4'd1);
          if (rem_q == 4'd1) state_d = S_IDLE;
`endif
        end
      end
`ifdef PKT_INJECTOR_CSUM_EN
      S_CSUM: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = csum_q;
          out_head_d  = 1'b0;
          out_tail_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dest_q      <= 8'd0;
      len_q       <= 4'd0;
      rem_q       <= 4'd0;
      seq_q       <= 16'd0;
      out_data_q  <= 32'd0;
      out_valid_q <= 1'b0;
      out_head_q  <= 1'b0;
      out_tail_q  <= 1'b0;
`ifdef PKT_INJECTOR_CSUM_EN
      csum_q      <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      seq_q       <= seq_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_head_q  <= out_head_d;
      out_tail_q  <= out_tail_d;
`ifdef PKT_INJECTOR_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

endmodule

`default_nettype wire
